// File: rtl/disp_pkg.sv
// rtl/disp_pkg.sv - shared state encoding, sizes and helpers for the display arbiter
package disp_pkg;

    localparam int NUM_SRC          = 4;
    localparam int SRC_W            = 16;
    localparam int DWELL_CYCLES_DEF = 10_000_000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DWELL = 2'd2
    } state_t;

    function automatic logic [NUM_SRC-1:0] onehot(input logic [1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick, searching upward from rr_ptr+1
module rr_arbiter
    import disp_pkg::*;
(
    input  logic [NUM_SRC-1:0] req,
    input  logic [1:0]         rr_ptr,
    output logic [1:0]         winner,
    output logic               any_req
);

    logic       found;
    logic [1:0] idx;

    // i = NUM_SRC wraps back to rr_ptr itself, so a lone requester can win again
    always_comb begin
        winner = rr_ptr;
        found  = 1'b0;
        idx    = rr_ptr;
        for (int i = 1; i <= NUM_SRC; i++) begin
            idx = rr_ptr + 2'(i);
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/display_arbiter.sv
// rtl/display_arbiter.sv - dwell-based round-robin owner of the seven-segment display; DISP_MANUAL_SEL_EN adds manual pinning
module display_arbiter
    import disp_pkg::*;
#(
    parameter int DWELL_CYCLES = DWELL_CYCLES_DEF,
    parameter int DWELL_W      = 24
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_SRC-1:0]       req,
    input  logic [NUM_SRC*SRC_W-1:0] src_data,
    input  logic                     manual_en,
    input  logic [1:0]               manual_sel,
    output logic [SRC_W-1:0]         data_out,
    output logic                     data_valid,
    output logic [NUM_SRC-1:0]       grant,
    output logic [NUM_SRC-1:0]       ack,
    output logic [1:0]               active_src
);

    localparam logic [DWELL_W-1:0] DWELL_LOAD = DWELL_W'(DWELL_CYCLES - 2);

    state_t               state, state_next;
    logic [DWELL_W-1:0]   cnt, cnt_d;
    logic [1:0]           rr_ptr, rr_ptr_d;
    logic [1:0]           winner;
    logic                 any_req;
    logic [SRC_W-1:0]     data_out_d;
    logic                 data_valid_d;
    logic [NUM_SRC-1:0]   grant_d, ack_d;
    logic [1:0]           active_src_d;

`ifndef DISP_MANUAL_SEL_EN
    logic unused_manual;
    assign unused_manual = ^{manual_en, manual_sel};
`endif

    rr_arbiter u_rr (
        .req     (req),
        .rr_ptr  (rr_ptr),
        .winner  (winner),
        .any_req (any_req)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (any_req) state_next = ST_LOAD;
            ST_LOAD:  state_next = any_req ? ST_DWELL : ST_IDLE;
            ST_DWELL: if (cnt == '0) state_next = any_req ? ST_LOAD : ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
`ifdef DISP_MANUAL_SEL_EN
        if (manual_en) state_next = ST_IDLE;
`endif
    end

    // Display side holds its last value unless a LOAD captures a new snapshot
    always_comb begin
        data_out_d   = data_out;
        data_valid_d = data_valid;
        grant_d      = grant;
        active_src_d = active_src;
        ack_d        = '0;
        rr_ptr_d     = rr_ptr;
        cnt_d        = cnt;
        case (state)
            ST_IDLE: grant_d = '0;
            ST_LOAD: begin
                if (any_req) begin
                    data_out_d   = src_data[SRC_W*int'(winner) +: SRC_W];
                    data_valid_d = 1'b1;
                    grant_d      = onehot(winner);
                    active_src_d = winner;
                    ack_d        = onehot(winner);
                    rr_ptr_d     = winner;
                    cnt_d        = DWELL_LOAD;
                end else begin
                    grant_d = '0;
                end
            end
            ST_DWELL: begin
                if (cnt != '0)    cnt_d   = cnt - DWELL_W'(1);
                else if (!any_req) grant_d = '0;
            end
            default: grant_d = '0;
        endcase
`ifdef DISP_MANUAL_SEL_EN
        if (manual_en) begin
            data_out_d   = src_data[SRC_W*int'(manual_sel) +: SRC_W];
            data_valid_d = 1'b1;
            grant_d      = onehot(manual_sel);
            active_src_d = manual_sel;
            ack_d        = '0;
            rr_ptr_d     = rr_ptr;
            cnt_d        = '0;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            grant      <= '0;
            ack        <= '0;
            active_src <= 2'd0;
            rr_ptr     <= 2'd3;
            cnt        <= '0;
        end else begin
            data_out   <= data_out_d;
            data_valid <= data_valid_d;
            grant      <= grant_d;
            ack        <= ack_d;
            active_src <= active_src_d;
            rr_ptr     <= rr_ptr_d;
            cnt        <= cnt_d;
        end
    end

endmodule

// File: tb/tb_display_arbiter.sv
// tb/tb_display_arbiter.sv - randomized scoreboard bench for display_arbiter against an event-schedule model
module tb_display_arbiter;

    localparam int DWELL = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req = '0;
    logic [63:0] src_data = '0;
    logic        manual_en = 1'b0;
    logic [1:0]  manual_sel = '0;
    logic [15:0] data_out;
    logic        data_valid;
    logic [3:0]  grant, ack;
    logic [1:0]  active_src;

    display_arbiter #(.DWELL_CYCLES(DWELL), .DWELL_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .src_data   (src_data),
        .manual_en  (manual_en),
        .manual_sel (manual_sel),
        .data_out   (data_out),
        .data_valid (data_valid),
        .grant      (grant),
        .ack        (ack),
        .active_src (active_src)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  ack;
        logic [15:0] data;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    bit          started = 0;

    // Model: display state plus scheduled capture / release-decision times
    int          cyc = 0;
    int          last_win = 3;
    bit          busy = 0;
    int          capture_at = -1;
    int          decide_at = -1;
    logic [15:0] exp_data = '0;
    logic [3:0]  exp_grant = '0;
    logic [1:0]  exp_src = '0;
    logic        exp_valid = 1'b0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, want, $time);
        end
    endtask

    task automatic capture();
        int   w;
        bit   found;
        exp_t e;
        w = 0;
        found = 0;
        for (int k = 1; k <= 4; k++) begin
            if (!found && req[(last_win + k) % 4]) begin
                w = (last_win + k) % 4;
                found = 1;
            end
        end
        exp_data  = src_data[16*w +: 16];
        exp_grant = 4'(1 << w);
        exp_src   = 2'(w);
        exp_valid = 1'b1;
        last_win  = w;
        e.ack  = exp_grant;
        e.data = exp_data;
        exp_q.push_back(e);
        decide_at = cyc + DWELL - 1;
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                busy = 0; capture_at = -1; decide_at = -1; last_win = 3;
                exp_data = '0; exp_grant = '0; exp_src = '0; exp_valid = 1'b0;
            end else begin
                cyc++;
`ifdef DISP_MANUAL_SEL_EN
                if (manual_en) begin
                    exp_data  = src_data[16*manual_sel +: 16];
                    exp_grant = 4'(1 << manual_sel);
                    exp_src   = manual_sel;
                    exp_valid = 1'b1;
                    busy = 0; capture_at = -1; decide_at = -1;
                end else
`endif
                if (capture_at == cyc) begin
                    capture_at = -1;
                    if (req != 0) capture();
                    else begin exp_grant = '0; busy = 0; end
                end else if (decide_at == cyc) begin
                    decide_at = -1;
                    if (req != 0) capture_at = cyc + 1;
                    else begin exp_grant = '0; busy = 0; end
                end else if (!busy) begin
                    exp_grant = '0;
                    if (req != 0) begin busy = 1; capture_at = cyc + 1; end
                end
            end
        end
    end

    // Monitor: pops on every ack pulse, and checks held display state each cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (started) begin
                if (ack != 0) begin
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL ack_unexpected actual=%b required=0000 at %0t", ack, $time);
                    end else begin
                        e = exp_q.pop_front();
                        chk("ack", 16'(ack), 16'(e.ack));
                        chk("ack_data", data_out, e.data);
                    end
                end else if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    checks++; errors++;
                    $display("FAIL ack_missing actual=0000 required=%b at %0t", e.ack, $time);
                end
                chk("grant", 16'(grant), 16'(exp_grant));
                chk("data_out", data_out, exp_data);
                chk("data_valid", 16'(data_valid), 16'(exp_valid));
                chk("active_src", 16'(active_src), 16'(exp_src));
            end
        end
    end

    task automatic idle_cycles(input int n);
        req = '0;
        repeat (n) begin @(posedge clk); #2; end
    endtask

    initial begin
        @(posedge clk); #2;
        started = 1;
        @(posedge clk); #2;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_data_out", data_out, 16'h0000);
        chk("rst_valid", 16'(data_valid), 16'h0);
        chk("rst_grant", 16'(grant), 16'h0);
        chk("rst_ack", 16'(ack), 16'h0);
        @(posedge clk); #2;

        // First grant latency
        src_data = 64'h0000_0000_0000_1234;
        req = 4'b0001;
        @(posedge clk); @(posedge clk); @(negedge clk);
        chk("first_ack", 16'(ack), 16'h0001);
        chk("first_data", data_out, 16'h1234);
        chk("first_grant", 16'(grant), 16'h0001);
        chk("first_src", 16'(active_src), 16'h0);
        @(posedge clk); #2;
        idle_cycles(8);

        // All four requesting: strict rotation
        src_data = 64'h000D_000C_000B_000A;
        req = 4'b1111;
        repeat (22) begin @(posedge clk); #2; end
        idle_cycles(8);

        // Granted source changes data and drops req mid-dwell
        src_data = 64'h0000_0000_0000_5555;
        req = 4'b0100;
        repeat (3) begin @(posedge clk); #2; end
        src_data = 64'h0000_AAAA_0000_0000;
        req = 4'b0000;
        idle_cycles(8);

        // Reset in the second dwell cycle
        req = 4'b0001;
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        chk("midrst_data", data_out, 16'h0000);
        chk("midrst_grant", 16'(grant), 16'h0);
        chk("midrst_ack", 16'(ack), 16'h0);
        chk("midrst_src", 16'(active_src), 16'h0);
        @(posedge clk); #2;
        reset = 1'b0;
        src_data = 64'h0000_0000_B0B1_0000;
        req = 4'b0010;
        @(posedge clk); @(posedge clk); @(negedge clk);
        chk("post_rst_grant", 16'(grant), 16'h0002);
        chk("post_rst_src", 16'(active_src), 16'h1);
        @(posedge clk); #2;
        idle_cycles(8);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom);
            if ($urandom_range(0, 1) == 0) src_data = {$urandom, $urandom};
            manual_en  = ($urandom_range(0, 15) == 0);
            manual_sel = 2'($urandom);
            @(posedge clk); #2;
        end
        manual_en = 1'b0;
        idle_cycles(10);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/display_arbiter.md
DISPLAY_ARBITER -- requirements
Module: display_arbiter

Interface
REQ-001 SHALL have parameter DWELL_CYCLES, default 10_000_000, minimum cycles a granted source stays displayed (must be >= 2).
REQ-002 SHALL have parameter DWELL_W, default 24, dwell counter width.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req  input  4  per-source display request, level.
REQ-006 SHALL have port src_data  input  64  four 16-bit source values; source i at [16i+15:16i].
REQ-007 SHALL have port manual_en  input  1  manual override enable.
REQ-008 SHALL have port manual_sel  input  2  manually pinned source index.
REQ-009 SHALL have port data_out  output  16  value fed to the seven-segment driver data_in.
REQ-010 SHALL have port data_valid  output  1  data_out holds a granted value.
REQ-011 SHALL have port grant  output  4  one-hot owner of the display, zero when none.
REQ-012 SHALL have port ack  output  4  one-cycle pulse to the source whose data was captured.
REQ-013 SHALL have port active_src  output  2  binary index of the last or current owner.

Function
REQ-014 SHALL implement FSM states IDLE, LOAD, DWELL; all outputs registered.
REQ-015 IDLE: when req != 0, SHALL go to LOAD; otherwise stay; grant = 0 in IDLE.
REQ-016 LOAD (one cycle): SHALL pick the winner round-robin from rr_ptr+1 upward (wrapping 3->0), latch its src_data slice into data_out, set data_valid=1, grant/active_src to winner, pulse ack[winner], set rr_ptr=winner, load the counter with DWELL_CYCLES-2, go to DWELL.
REQ-017 Latency: req seen in IDLE at edge n -> data_out/ack/grant valid after edge n+2.
REQ-018 DWELL: SHALL decrement the counter each cycle; data_out is a snapshot and SHALL NOT track src_data changes.
REQ-019 Counter == 0 in DWELL: SHALL go to LOAD if req != 0 (same source may win again if it is the only requester), else IDLE.
REQ-020 Dropping req of the granted source mid-DWELL SHALL NOT shorten the dwell.
REQ-021 In IDLE, data_out, data_valid and active_src SHALL hold their last values (display keeps last value).
REQ-022 Simultaneous requests SHALL be served in strict rotation; with all four asserted continuously the order is 0,1,2,3,0...
REQ-023 ack SHALL be one-hot or zero and asserted only in the LOAD cycle.

Reset
REQ-024 On reset, outputs SHALL be: data_out=0, data_valid=0, grant=0, ack=0, active_src=0; state=IDLE, counter=0, rr_ptr=3 so source 0 wins first.
REQ-025 Reset asserted mid-DWELL or mid-LOAD SHALL abort immediately with no ack pulse after release until a new LOAD occurs.

Configuration
REQ-026 Macro DISP_MANUAL_SEL_EN defined: manual_en=1 SHALL force state IDLE-hold, set grant=onehot(manual_sel), active_src=manual_sel, data_valid=1, register src_data[manual_sel] into data_out every cycle (1-cycle latency), and suppress ack.
REQ-027 Manual mode SHALL take priority over every FSM state; on manual_en fall the FSM SHALL resume in IDLE with the counter cleared and rr_ptr unchanged.
REQ-028 Macro undefined: manual_en and manual_sel SHALL remain as ports but be ignored; no manual logic is synthesized.

Structure
REQ-029 Package disp_pkg SHALL hold the state encoding, NUM_SRC=4, SRC_W=16 and the default DWELL_CYCLES constant.
REQ-030 Round-robin selection SHALL be a combinational sub-module rr_arbiter (inputs req, rr_ptr; outputs winner index and any_req).

Verification (bench DWELL_CYCLES=4)
REQ-031 Reset, then req=4'b0001, src0=16'h1234 -> after 2 edges: ack=0001 for 1 cycle, data_out=1234, grant=0001, active_src=0, data_valid=1.
REQ-032 req=4'b1111, distinct data 000A/000B/000C/000D -> grants 0,1,2,3,0, each held exactly 4 cycles; data_out follows the same order.
REQ-033 Granted src changes data and drops req mid-dwell -> data_out unchanged, dwell runs to 4 cycles, then IDLE with data_out held and grant=0.
REQ-034 Reset pulsed in the 2nd DWELL cycle -> all outputs return to their reset values at once; after release with req=0010, source 1 is granted.
REQ-035 With DISP_MANUAL_SEL_EN defined: manual_en=1, manual_sel=2, src2=BEEF -> data_out=BEEF next cycle, grant=0100, no ack; release -> FSM restarts from IDLE.
